main_mem_arbiter: RTL and testbench
===================================

MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, meaning block-address width (word address bits above 4-word block offset).
REQ-002 The block SHALL have parameter BLOCK_W, default 128, meaning cache-block data width.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports I_MEM_READ (in, 1), I_MEM_ADDRESS (in, ADDR_W), I_MEM_READDATA (out, BLOCK_W) and I_MEM_BUSYWAIT (out, 1), forming the instruction-cache refill port.
REQ-006 The block SHALL have ports D_MEM_READ (in, 1), D_MEM_WRITE (in, 1), D_MEM_ADDRESS (in, ADDR_W), D_MEM_WRITEDATA (in, BLOCK_W), D_MEM_READDATA (out, BLOCK_W) and D_MEM_BUSYWAIT (out, 1), forming the data-cache refill/write-back port.
REQ-007 The block SHALL have ports MEM_READ (out, 1), MEM_WRITE (out, 1), MEM_ADDRESS (out, ADDR_W), MEM_WRITEDATA (out, BLOCK_W), MEM_READDATA (in, BLOCK_W) and MEM_BUSYWAIT (in, 1), forming the shared main-memory port.
REQ-008 The block SHALL have port GRANT, output, 2 bits: 00 none, 01 I-cache, 10 D-cache, 11 never driven.

Function
REQ-009 The block SHALL implement states IDLE, SERVE_I and SERVE_D, plus a 1-bit FIRST flag that is set on entry to either SERVE state.
REQ-010 In IDLE with a D request (D_MEM_READ or D_MEM_WRITE) and no I request, the block SHALL go to SERVE_D at the next edge.
REQ-011 In IDLE with I_MEM_READ and no D request, the block SHALL go to SERVE_I at the next edge.
REQ-012 In IDLE with both requests, the block SHALL select per REQ-025/REQ-026.
REQ-013 In SERVE_x, the block SHALL drive the granted requester's read/write/address/writedata onto the MEM_* outputs; in IDLE, MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA SHALL be 0.
REQ-014 For SERVE_I, MEM_WRITE SHALL be 0 and MEM_WRITEDATA SHALL be 0.
REQ-015 The block SHALL assert combinational DONE = SERVE_x and FIRST=0 and MEM_BUSYWAIT=0; the first SERVE cycle SHALL never complete, regardless of MEM_BUSYWAIT.
REQ-016 On the edge where DONE=1, the block SHALL return to IDLE; there is no back-to-back grant without one IDLE cycle.
REQ-017 x_MEM_BUSYWAIT SHALL equal (x request asserted) and not (granted to x and DONE); a requester therefore sees busywait fall exactly in its completion cycle, and a requester not requesting sees 0.
REQ-018 I_MEM_READDATA and D_MEM_READDATA SHALL pass MEM_READDATA through combinationally when that port is granted, and be 0 otherwise.
REQ-019 Minimum transaction latency SHALL be 1 IDLE cycle plus 2 SERVE cycles with a zero-wait memory; each memory busy cycle adds one cycle.
REQ-020 Once granted, the grant SHALL be held until DONE, even if the other requester asserts or the granted requester drops its request (the memory access still completes; its data is discarded).
REQ-021 If the D requester asserts both D_MEM_READ and D_MEM_WRITE, both SHALL be forwarded unchanged; memory defines the behaviour.
REQ-022 GRANT SHALL reflect the current state: 00 in IDLE, 01 in SERVE_I, 10 in SERVE_D.

Reset
REQ-023 While RESET=0, asynchronously, the block SHALL set state to IDLE, FIRST=0, the last-served register to I, and GRANT=00, and force all MEM_* outputs to 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction; after release, requests still asserted SHALL be re-arbitrated from IDLE, and x_MEM_BUSYWAIT SHALL follow REQ-017.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, a last-served register SHALL update on each DONE, and simultaneous requests in IDLE SHALL be granted to the requester not last served.
REQ-026 Without ARB_ROUND_ROBIN_EN, D SHALL have fixed priority over I, with no last-served register; I may starve under continuous D traffic.

Verification
REQ-027 The bench SHALL cover: I read 0x0000040 alone, memory busy 3 cycles, data 0x1111...1 -> GRANT 01, MEM_ADDRESS 0x0000040, I_MEM_BUSYWAIT falls in cycle 5 after the request, I_MEM_READDATA 0x1111...1.
REQ-028 The bench SHALL cover: D write 0x0000080, data 0xAAAA...A, zero-wait memory -> MEM_WRITE=1 for 2 cycles, D_MEM_BUSYWAIT high 2 cycles then low, MEM_READ=0.
REQ-029 The bench SHALL cover: I and D requesting simultaneously, repeated twice -> without the macro, grants are D, D; with ARB_ROUND_ROBIN_EN, grants are D then I (last-served resets to I).
REQ-030 The bench SHALL cover: D asserted while SERVE_I is active -> grant stays 01 until DONE, one IDLE cycle follows, then 10; D_MEM_BUSYWAIT stays high throughout.
REQ-031 The bench SHALL cover: RESET pulled low in the second cycle of SERVE_D -> MEM_READ/MEM_WRITE drop immediately, GRANT 00; after release, the held D request is re-granted and completes.

Source files
------------

// File: rtl/main_mem_arbiter.sv
// Shares one main-memory port between I-cache refill and D-cache refill/write-back; define ARB_ROUND_ROBIN_EN for round-robin ties.
// Latency: one IDLE cycle plus two SERVE cycles minimum, plus one cycle per MEM_BUSYWAIT cycle.
// Backpressure: a requester's busywait stays high until its completion cycle; the grant is held until DONE.
module main_mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_MEM_READ,
    input  logic [ADDR_W-1:0]  I_MEM_ADDRESS,
    output logic [BLOCK_W-1:0] I_MEM_READDATA,
    output logic               I_MEM_BUSYWAIT,
    input  logic               D_MEM_READ,
    input  logic               D_MEM_WRITE,
    input  logic [ADDR_W-1:0]  D_MEM_ADDRESS,
    input  logic [BLOCK_W-1:0] D_MEM_WRITEDATA,
    output logic [BLOCK_W-1:0] D_MEM_READDATA,
    output logic               D_MEM_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT,
    output logic [1:0]         GRANT
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   first;
    logic   i_req;
    logic   d_req;
    logic   done;
    logic   pick_d;

    assign i_req = I_MEM_READ;
    assign d_req = D_MEM_READ | D_MEM_WRITE;

    // The first SERVE cycle never completes: memory has not yet seen the request.
    assign done = (state != IDLE) && !first && !MEM_BUSYWAIT;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_d <= 1'b0;
        end else if (done) begin
            last_d <= (state == SERVE_D);
        end
    end

    assign pick_d = d_req && (!i_req || !last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            first <= (state == IDLE) && (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = SERVE_D;
                end else if (i_req) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        GRANT         = 2'b00;
        case (state)
            SERVE_I: begin
                MEM_READ    = I_MEM_READ;
                MEM_ADDRESS = I_MEM_ADDRESS;
                GRANT       = 2'b01;
            end
            SERVE_D: begin
                MEM_READ      = D_MEM_READ;
                MEM_WRITE     = D_MEM_WRITE;
                MEM_ADDRESS   = D_MEM_ADDRESS;
                MEM_WRITEDATA = D_MEM_WRITEDATA;
                GRANT         = 2'b10;
            end
            default: ;
        endcase
    end

    assign I_MEM_READDATA = (state == SERVE_I) ? MEM_READDATA : '0;
    assign D_MEM_READDATA = (state == SERVE_D) ? MEM_READDATA : '0;
    assign I_MEM_BUSYWAIT = i_req && !((state == SERVE_I) && done);
    assign D_MEM_BUSYWAIT = d_req && !((state == SERVE_D) && done);

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Bench for main_mem_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
module tb_main_mem_arbiter;
    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               I_MEM_READ = 1'b0;
    logic [ADDR_W-1:0]  I_MEM_ADDRESS = '0;
    logic [BLOCK_W-1:0] I_MEM_READDATA;
    logic               I_MEM_BUSYWAIT;
    logic               D_MEM_READ = 1'b0;
    logic               D_MEM_WRITE = 1'b0;
    logic [ADDR_W-1:0]  D_MEM_ADDRESS = '0;
    logic [BLOCK_W-1:0] D_MEM_WRITEDATA = '0;
    logic [BLOCK_W-1:0] D_MEM_READDATA;
    logic               D_MEM_BUSYWAIT;
    logic               MEM_READ;
    logic               MEM_WRITE;
    logic [ADDR_W-1:0]  MEM_ADDRESS;
    logic [BLOCK_W-1:0] MEM_WRITEDATA;
    logic [BLOCK_W-1:0] MEM_READDATA;
    logic               MEM_BUSYWAIT;
    logic [1:0]         GRANT;

    int checks = 0;
    int failures = 0;

    // Memory model: access cycle count since MEM_READ/MEM_WRITE rose; busy for mem_wait cycles after the first.
    int                 mem_wait = 0;
    int                 acc_cnt = 0;
    logic               mem_use_addr = 1'b1;
    logic [BLOCK_W-1:0] mem_fixed = '0;
    bit                 last_d = 1'b0;

    function automatic logic [BLOCK_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {4{4'h5, a}};
    endfunction

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (MEM_READ || MEM_WRITE) acc_cnt = acc_cnt + 1;
        else acc_cnt = 0;
    end

    assign MEM_BUSYWAIT = (acc_cnt >= 2) && (acc_cnt <= mem_wait + 1);
    assign MEM_READDATA = mem_use_addr ? mem_word(MEM_ADDRESS) : mem_fixed;

    main_mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_MEM_READ(I_MEM_READ), .I_MEM_ADDRESS(I_MEM_ADDRESS),
        .I_MEM_READDATA(I_MEM_READDATA), .I_MEM_BUSYWAIT(I_MEM_BUSYWAIT),
        .D_MEM_READ(D_MEM_READ), .D_MEM_WRITE(D_MEM_WRITE), .D_MEM_ADDRESS(D_MEM_ADDRESS),
        .D_MEM_WRITEDATA(D_MEM_WRITEDATA), .D_MEM_READDATA(D_MEM_READDATA),
        .D_MEM_BUSYWAIT(D_MEM_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .GRANT(GRANT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        last_d = 1'b0;
    endtask

    task automatic test_reset();
        #2 RESET = 1'b0;
        I_MEM_READ = 1'b1;
        tick();
        @(negedge CLK);
        checks++;
        if (GRANT !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", GRANT); end
        checks++;
        if ({MEM_READ, MEM_WRITE} !== 2'b00 || MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0) begin
            failures++; $display("FAIL reset_mem_outputs rd=%b wr=%b addr=%0h", MEM_READ, MEM_WRITE, MEM_ADDRESS);
        end
        checks++;
        if (I_MEM_BUSYWAIT !== 1'b1 || D_MEM_BUSYWAIT !== 1'b0) begin
            failures++; $display("FAIL reset_busywait i=%b d=%b exp i=1 d=0", I_MEM_BUSYWAIT, D_MEM_BUSYWAIT);
        end
        checks++;
        if (I_MEM_READDATA !== '0) begin failures++; $display("FAIL reset_i_readdata got=%0h exp=0", I_MEM_READDATA); end
        I_MEM_READ = 1'b0;
        tick();
        RESET = 1'b1;
        last_d = 1'b0;
        tick();
    endtask

    task automatic test_i_read();
        int fall = -1;
        mem_use_addr = 1'b0;
        mem_fixed = {32{4'h1}};
        mem_wait = 3;
        I_MEM_ADDRESS = 28'h0000040;
        I_MEM_READ = 1'b1;
        for (int c = 0; c < 12 && fall < 0; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                checks++;
                if (GRANT !== 2'b01 || MEM_ADDRESS !== 28'h0000040 || MEM_WRITE !== 1'b0) begin
                    failures++; $display("FAIL i_read_grant grant=%b addr=%0h wr=%b exp 01/40/0", GRANT, MEM_ADDRESS, MEM_WRITE);
                end
            end
            if (!I_MEM_BUSYWAIT) begin
                fall = c;
                checks++;
                if (I_MEM_READDATA !== {32{4'h1}}) begin
                    failures++; $display("FAIL i_read_data got=%0h exp=%0h", I_MEM_READDATA, {32{4'h1}});
                end
            end
            tick();
        end
        I_MEM_READ = 1'b0;
        mem_use_addr = 1'b1;
        checks++;
        if (fall != 5) begin failures++; $display("FAIL i_read_latency got=%0d exp=5", fall); end
    endtask

    task automatic test_d_write();
        int   whigh = 0;
        bit   rd_seen = 1'b0;
        logic [3:0] bw = '0;
        mem_wait = 0;
        D_MEM_ADDRESS = 28'h0000080;
        D_MEM_WRITEDATA = {32{4'hA}};
        D_MEM_WRITE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (MEM_WRITE) whigh++;
            if (MEM_READ) rd_seen = 1'b1;
            bw[c] = D_MEM_BUSYWAIT;
            if (c == 1) begin
                checks++;
                if (MEM_WRITEDATA !== {32{4'hA}} || MEM_ADDRESS !== 28'h0000080) begin
                    failures++; $display("FAIL d_write_bus data=%0h addr=%0h", MEM_WRITEDATA, MEM_ADDRESS);
                end
            end
            tick();
            if (c == 2) D_MEM_WRITE = 1'b0;
        end
        checks++;
        if (whigh != 2) begin failures++; $display("FAIL d_write_cycles got=%0d exp=2", whigh); end
        checks++;
        if (rd_seen) begin failures++; $display("FAIL d_write_memread got=1 exp=0"); end
        checks++;
        if (bw !== 4'b0011) begin failures++; $display("FAIL d_write_busywait got=%b exp=0011", bw); end
    endtask

    // One transaction episode. The model: a lone request completes 2+w cycles after it is presented;
    // with both present the tie-break winner completes at 2+w, and the loser (if it keeps requesting)
    // waits one IDLE cycle after that and then takes its own 2+w, i.e. 5+2w.
    task automatic run_txn(input bit ri, input bit rd, input bit dwr, input int w,
                           input bit drop_all, output logic [1:0] first_grant);
        logic [ADDR_W-1:0]  ia;
        logic [ADDR_W-1:0]  da;
        logic [BLOCK_W-1:0] wd;
        bit d_wins;
        int exp_i = -1, exp_d = -1, got_i = -1, got_d = -1;
        bit ip, dp, stray = 1'b0;
        ia = ADDR_W'($urandom);
        da = ADDR_W'($urandom);
        wd = {$urandom, $urandom, $urandom, $urandom};
`ifdef ARB_ROUND_ROBIN_EN
        d_wins = rd && (!ri || !last_d);
`else
        d_wins = rd;
`endif
        if (ri && rd) begin
            if (d_wins) begin exp_d = 2 + w; exp_i = drop_all ? -1 : 5 + 2 * w; end
            else begin exp_i = 2 + w; exp_d = drop_all ? -1 : 5 + 2 * w; end
        end else if (ri) exp_i = 2 + w;
        else exp_d = 2 + w;
        first_grant = 2'bxx;
        mem_wait = w;
        I_MEM_ADDRESS = ia; D_MEM_ADDRESS = da; D_MEM_WRITEDATA = wd;
        I_MEM_READ = ri; D_MEM_READ = rd && !dwr; D_MEM_WRITE = rd && dwr;
        ip = ri; dp = rd;
        for (int c = 0; c < 30 && (ip || dp); c++) begin
            @(negedge CLK);
            if (c == 1) first_grant = GRANT;
            if ((!ri && I_MEM_BUSYWAIT) || (!rd && D_MEM_BUSYWAIT)) stray = 1'b1;
            if (ip && !I_MEM_BUSYWAIT) begin
                got_i = c; ip = 1'b0;
                checks++;
                if (GRANT !== 2'b01 || I_MEM_READDATA !== mem_word(ia)) begin
                    failures++; $display("FAIL txn_i_done grant=%b data=%0h exp 01/%0h", GRANT, I_MEM_READDATA, mem_word(ia));
                end
                if (drop_all) dp = 1'b0;
            end
            if (dp && !D_MEM_BUSYWAIT) begin
                got_d = c; dp = 1'b0;
                checks++;
                if (GRANT !== 2'b10 || MEM_WRITE !== dwr || (dwr && MEM_WRITEDATA !== wd)
                    || (!dwr && D_MEM_READDATA !== mem_word(da))) begin
                    failures++; $display("FAIL txn_d_done grant=%b wr=%b data=%0h", GRANT, MEM_WRITE, D_MEM_READDATA);
                end
                if (drop_all) ip = 1'b0;
            end
            tick();
            if (!ip) I_MEM_READ = 1'b0;
            if (!dp) begin D_MEM_READ = 1'b0; D_MEM_WRITE = 1'b0; end
        end
        I_MEM_READ = 1'b0; D_MEM_READ = 1'b0; D_MEM_WRITE = 1'b0;
        checks++;
        if (got_i != exp_i || got_d != exp_d) begin
            failures++; $display("FAIL txn_latency i=%0d/%0d d=%0d/%0d (got/exp) ri=%b rd=%b w=%0d", got_i, exp_i, got_d, exp_d, ri, rd, w);
        end
        checks++;
        if (stray) begin failures++; $display("FAIL txn_idle_busywait got=1 exp=0"); end
        if (ri && rd && !drop_all) last_d = !d_wins;
        else last_d = d_wins;
    endtask

    task automatic test_simultaneous();
        logic [1:0] g0, g1;
        pulse_reset();
        run_txn(1'b1, 1'b1, 1'b0, 0, 1'b1, g0);
        run_txn(1'b1, 1'b1, 1'b0, 0, 1'b1, g1);
        checks++;
        if (g0 !== 2'b10) begin failures++; $display("FAIL simul_first got=%b exp=10", g0); end
        checks++;
`ifdef ARB_ROUND_ROBIN_EN
        if (g1 !== 2'b01) begin failures++; $display("FAIL simul_second got=%b exp=01", g1); end
`else
        if (g1 !== 2'b10) begin failures++; $display("FAIL simul_second got=%b exp=10", g1); end
`endif
    endtask

    task automatic test_preempt();
        logic [1:0] exp_g [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
        mem_wait = 1;
        I_MEM_ADDRESS = ADDR_W'($urandom);
        D_MEM_ADDRESS = ADDR_W'($urandom);
        I_MEM_READ = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            checks++;
            if (GRANT !== exp_g[c]) begin failures++; $display("FAIL preempt_grant c=%0d got=%b exp=%b", c, GRANT, exp_g[c]); end
            if (c >= 1 && c <= 7) begin
                checks++;
                if (D_MEM_BUSYWAIT !== (c != 7)) begin
                    failures++; $display("FAIL preempt_d_busywait c=%0d got=%b exp=%b", c, D_MEM_BUSYWAIT, c != 7);
                end
            end
            tick();
            if (c == 0) D_MEM_READ = 1'b1;
            if (c == 3) I_MEM_READ = 1'b0;
            if (c == 7) D_MEM_READ = 1'b0;
        end
        last_d = 1'b1;
    endtask

    task automatic test_reset_mid();
        int fall = -1;
        logic [ADDR_W-1:0] da;
        da = ADDR_W'($urandom);
        mem_wait = 2;
        D_MEM_ADDRESS = da;
        D_MEM_READ = 1'b1;
        tick();
        tick();
        #2 RESET = 1'b0;
        #1;
        checks++;
        if ({MEM_READ, MEM_WRITE} !== 2'b00 || GRANT !== 2'b00) begin
            failures++; $display("FAIL resetmid_drop rd=%b wr=%b grant=%b exp 0/0/00", MEM_READ, MEM_WRITE, GRANT);
        end
        checks++;
        if (D_MEM_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL resetmid_busywait got=%b exp=1", D_MEM_BUSYWAIT); end
        tick();
        RESET = 1'b1;
        last_d = 1'b0;
        for (int c = 0; c < 12 && fall < 0; c++) begin
            @(negedge CLK);
            if (!D_MEM_BUSYWAIT) begin
                fall = c;
                checks++;
                if (D_MEM_READDATA !== mem_word(da) || GRANT !== 2'b10) begin
                    failures++; $display("FAIL resetmid_data got=%0h grant=%b exp=%0h/10", D_MEM_READDATA, GRANT, mem_word(da));
                end
            end
            tick();
        end
        D_MEM_READ = 1'b0;
        last_d = 1'b1;
        checks++;
        if (fall != 4) begin failures++; $display("FAIL resetmid_latency got=%0d exp=4", fall); end
    endtask

    task automatic test_random();
        logic [1:0] g;
        bit ri, rd;
        for (int n = 0; n < 40; n++) begin
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) ri = 1'b1;
            run_txn(ri, rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) == 0), g);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_simultaneous();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
